// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply issue/control slice: RISC-V M-extension
// multiply op encodings, multiplier signedness pairs and the control FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  // Signed pair sent to the multiplier: bit1 = multiplicand, bit0 = multiplier.
  localparam logic [1:0] SIGNED_UU = 2'b00;
  localparam logic [1:0] SIGNED_US = 2'b01;
  localparam logic [1:0] SIGNED_SU = 2'b10;
  localparam logic [1:0] SIGNED_SS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } mul_state_e;

  // Operand signedness implied by the op. MUL only uses the low half of the
  // product, which is the same for any signedness, so it shares the SS pair.
  function automatic logic [1:0] op_signed_pair(input mul_op_e op);
    case (op)
      OP_MULHSU: return SIGNED_SU;
      OP_MULHU:  return SIGNED_UU;
      default:   return SIGNED_SS;
    endcase
  endfunction

endpackage

// File: rtl/mul_result_fmt.sv
// Writeback formatter: picks the product half an op architecturally returns
// and sign-extends the low word for MULW. Purely combinational.
module mul_result_fmt
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  mul_op_e         op,
  input  logic            is_w,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] data
);

  // High ops return the upper half; MUL returns the low half, MULW its sign-extended low word.
  always_comb begin
    // NOTE: data gets a value before any branch so no path leaves it unassigned (no latch).
    data = hi;
    if (op == OP_MUL) begin
      data = is_w ? {{(XLEN/2){lo[XLEN/2-1]}}, lo[XLEN/2-1:0]} : lo;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller between the execute stage and a Booth/Wallace
// multiplier. Accepts one op at a time, drives the multiplier handshake with
// held operands, captures hi/lo and returns one formatted word on wb_*.
// Optional build macro MUL_RESULT_CACHE_EN adds a one-entry result cache that
// short-circuits repeated operand pairs straight to the response state.
module mul_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [1:0]      mul_op,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            m_mul_valid,
  input  logic            m_mul_ready,
  output logic            m_mulw,
  output logic [1:0]      m_mul_signed,
  output logic [XLEN-1:0] m_multiplicand,
  output logic [XLEN-1:0] m_multiplier,
  output logic            m_flush,
  input  logic            m_out_valid,
  input  logic [XLEN-1:0] m_result_hi,
  input  logic [XLEN-1:0] m_result_lo,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data
);

  mul_state_e      state_q, state_d;
  mul_op_e         op_q;
  logic            w_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [1:0]      sgn_q;
  logic [XLEN-1:0] wb_data_q;
  logic            m_flush_q;

  mul_op_e         op_in;
  logic            w_in;
  logic [1:0]      sgn_in;
  logic            accept;
  logic            capture;
  logic            hit;

  mul_op_e         fmt_op;
  logic            fmt_w;
  logic [XLEN-1:0] fmt_hi, fmt_lo, fmt_data;

  assign op_in   = mul_op_e'(mul_op);
  assign w_in    = is_w && (op_in == OP_MUL);
  assign sgn_in  = op_signed_pair(op_in);
  assign accept  = ex_valid && ex_ready;
  // A result arriving together with a flush belongs to a killed op.
  assign capture = (state_q == ST_WAIT) && m_out_valid && !flush;

`ifdef MUL_RESULT_CACHE_EN
  logic            c_valid_q;
  logic [XLEN-1:0] c_src1_q, c_src2_q, c_hi_q, c_lo_q;
  logic [1:0]      c_sgn_q;

  // Low-half ops ignore signedness; high-half ops must see the same signed pair.
  assign hit = c_valid_q && (c_src1_q == src1) && (c_src2_q == src2) &&
               ((op_in == OP_MUL) || (c_sgn_q == sgn_in));

  // Cache entry valid bit: set by any completed full-width capture, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
    end else if (capture && !w_q) begin
      c_valid_q <= 1'b1;
    end
  end

  // Cache entry payload: qualified by c_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: storage behind a valid bit is left unreset; only the valid bit must come up known.
    if (capture && !w_q) begin
      c_src1_q <= src1_q;
      c_src2_q <= src2_q;
      c_sgn_q  <= sgn_q;
      c_hi_q   <= m_result_hi;
      c_lo_q   <= m_result_lo;
    end
  end

  // Formatter sees the incoming op and cached product in IDLE, the live product otherwise.
  always_comb begin
    fmt_op = op_q;
    fmt_w  = w_q;
    fmt_hi = m_result_hi;
    fmt_lo = m_result_lo;
    if (state_q == ST_IDLE) begin
      fmt_op = op_in;
      fmt_w  = w_in;
      fmt_hi = c_hi_q;
      fmt_lo = c_lo_q;
    end
  end
`else
  assign hit    = 1'b0;
  assign fmt_op = op_q;
  assign fmt_w  = w_q;
  assign fmt_hi = m_result_hi;
  assign fmt_lo = m_result_lo;
`endif

  mul_result_fmt #(.XLEN(XLEN)) u_fmt (
    .op   (fmt_op),
    .is_w (fmt_w),
    .hi   (fmt_hi),
    .lo   (fmt_lo),
    .data (fmt_data)
  );

  // Next-state logic; a flush overrides every handshake and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)                      state_d = hit ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (m_mul_valid && m_mul_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (m_out_valid)                 state_d = ST_RESP;
      ST_RESP:  if (wb_valid && wb_ready)        state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State, latched op/operands, registered writeback word and multiplier flush pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      w_q       <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      sgn_q     <= SIGNED_UU;
      wb_data_q <= '0;
      m_flush_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Only a multiplier holding an op needs to be told to drop it.
      m_flush_q <= flush && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
      if (accept) begin
        op_q   <= op_in;
        w_q    <= w_in;
        src1_q <= src1;
        src2_q <= src2;
        sgn_q  <= sgn_in;
      end
      if (capture || (accept && hit)) begin
        wb_data_q <= fmt_data;
      end
    end
  end

  assign ex_ready       = (state_q == ST_IDLE) && !flush && !rst;
  assign m_mul_valid    = (state_q == ST_ISSUE) && !rst;
  assign m_mulw         = w_q;
  assign m_mul_signed   = sgn_q;
  assign m_multiplicand = src1_q;
  assign m_multiplier   = src2_q;
  assign m_flush        = m_flush_q;
  assign wb_valid       = (state_q == ST_RESP) && !flush && !rst;
  assign wb_data        = wb_data_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl at XLEN=16 with a behavioural multiplier whose
// ready delay and result latency are adjustable per test. Expected writeback
// words are queued at issue time and compared when wb_valid && wb_ready.
module tb_mul_issue_ctrl;
  import muldiv_pkg::*;

  localparam int XLEN = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ex_valid = 1'b0;
  logic            ex_ready;
  logic [1:0]      mul_op = 2'b00;
  logic            is_w = 1'b0;
  logic [XLEN-1:0] src1 = '0, src2 = '0;
  logic            flush = 1'b0;
  logic            m_mul_valid, m_mul_ready;
  logic            m_mulw;
  logic [1:0]      m_mul_signed;
  logic [XLEN-1:0] m_multiplicand, m_multiplier;
  logic            m_flush;
  logic            m_out_valid;
  logic [XLEN-1:0] m_result_hi, m_result_lo;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [XLEN-1:0] wb_data;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] sb_q[$];
  int cfg_rdy_delay = 0;
  int cfg_lat = 1;
  int wb_xfers = 0;
  int mv_cycles = 0;

  mul_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mul_op(mul_op), .is_w(is_w), .src1(src1), .src2(src2), .flush(flush),
    .m_mul_valid(m_mul_valid), .m_mul_ready(m_mul_ready), .m_mulw(m_mulw),
    .m_mul_signed(m_mul_signed), .m_multiplicand(m_multiplicand),
    .m_multiplier(m_multiplier), .m_flush(m_flush), .m_out_valid(m_out_valid),
    .m_result_hi(m_result_hi), .m_result_lo(m_result_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Reference result of an M-extension op on 16-bit operands.
  function automatic logic [XLEN-1:0] ref_res(input logic [1:0] op, input logic w,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint p;
    logic [31:0] p32;
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    p32 = p[31:0];
    if (op == 2'b00) return w ? {{8{p32[7]}}, p32[7:0]} : p32[15:0];
    return p32[31:16];
  endfunction

  function automatic logic [1:0] ref_sgn(input logic [1:0] op);
    case (op)
      2'b10:   return 2'b10;
      2'b11:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // Behavioural multiplier: ready after cfg_rdy_delay cycles, result cfg_lat cycles later.
  initial begin
    logic hs, fl;
    logic [XLEN-1:0] a, b;
    logic [1:0] sg;
    longint pa, pb, p;
    int rdy_cnt, lat_cnt;
    logic busy;
    m_mul_ready = 1'b0; m_out_valid = 1'b0;
    m_result_hi = '0; m_result_lo = '0;
    busy = 1'b0; rdy_cnt = 0; lat_cnt = 0;
    forever begin
      @(negedge clk);
      hs = m_mul_valid && m_mul_ready;
      fl = m_flush || rst;
      a = m_multiplicand; b = m_multiplier; sg = m_mul_signed;
      @(posedge clk); #1;
      m_out_valid = 1'b0;
      m_mul_ready = 1'b0;
      if (fl) begin
        busy = 1'b0;
      end else if (hs) begin
        pa = sg[1] ? longint'($signed(a)) : longint'(a);
        pb = sg[0] ? longint'($signed(b)) : longint'(b);
        p = pa * pb;
        m_result_hi = p[31:16];
        m_result_lo = p[15:0];
        busy = 1'b1;
        lat_cnt = cfg_lat;
      end else if (busy) begin
        if (lat_cnt == 0) begin
          m_out_valid = 1'b1;
          busy = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      if (!fl && !hs && !busy && m_mul_valid) begin
        if (rdy_cnt >= cfg_rdy_delay) m_mul_ready = 1'b1;
        else rdy_cnt++;
      end else begin
        rdy_cnt = 0;
      end
    end
  end

  // Scoreboard side: every writeback transfer must match the oldest queued result.
  always @(negedge clk) begin
    if (m_mul_valid) mv_cycles++;
    if (wb_valid && wb_ready) begin
      logic [XLEN-1:0] exp;
      wb_xfers++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_data=%h, required no transfer", wb_data);
      end else begin
        exp = sb_q.pop_front();
        if (wb_data !== exp) begin
          errors++;
          $display("FAIL wb_data: got %h, required %h", wb_data, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present an op, wait for acceptance, check issue-side fields, wait for its writeback.
  task automatic run_op(input logic [1:0] op, input logic w, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                        input logic [1:0] exp_sgn, input logic exp_mulw, input string name);
    int n;
    sb_q.push_back(exp);
    mul_op = op; is_w = w; src1 = a; src2 = b; ex_valid = 1'b1;
    #1;
    n = 0;
    while (!ex_ready && n < 50) begin tick(); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL %s ex_ready_timeout: got ex_ready=0 for 50 cycles, required 1", name);
    end
    tick();
    ex_valid = 1'b0;
    src1 = ~a; src2 = ~b;
    checks++;
    if ({m_mul_signed, m_mulw, m_multiplicand, m_multiplier} !== {exp_sgn, exp_mulw, a, b}) begin
      errors++;
      $display("FAIL %s issue_fields: got signed=%b mulw=%b a=%h b=%h, required signed=%b mulw=%b a=%h b=%h",
               name, m_mul_signed, m_mulw, m_multiplicand, m_multiplier, exp_sgn, exp_mulw, a, b);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin tick(); n++; end
    if (n == 200) begin
      checks++; errors++;
      $display("FAIL %s wb_timeout: got no writeback in 200 cycles, required one", name);
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    checks++;
    if (ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ex_ready: got %b during reset, required 0", ex_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ex_ready, m_mul_valid, wb_valid, m_flush, m_mulw, m_mul_signed, wb_data, m_multiplicand, m_multiplier}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 48'h0}) begin
      errors++;
      $display("FAIL reset_state: got ex_ready=%b mv=%b wbv=%b mfl=%b mulw=%b sgn=%b wbd=%h a=%h b=%h, required 1 0 0 0 0 00 0 0 0",
               ex_ready, m_mul_valid, wb_valid, m_flush, m_mulw, m_mul_signed, wb_data, m_multiplicand, m_multiplier);
    end
  endtask

  task automatic test_basic();
    cfg_rdy_delay = 0; cfg_lat = 1;
    run_op(2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 2'b11, 1'b0, "mul_ffff");
    run_op(2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b11, 1'b0, "mulh_ffff");
    run_op(2'b11, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 2'b00, 1'b0, "mulhu_ffff");
    run_op(2'b10, 1'b0, 16'hFFFE, 16'h0005, 16'hFFFF, 2'b10, 1'b0, "mulhsu_neg");
    run_op(2'b11, 1'b0, 16'hFFFE, 16'h0005, 16'h0004, 2'b00, 1'b0, "mulhu_neg");
    run_op(2'b00, 1'b1, 16'h0010, 16'h0008, 16'hFF80, 2'b11, 1'b1, "mulw");
    // is_w on a high op must be ignored.
    run_op(2'b01, 1'b1, 16'h0123, 16'h4567, ref_res(2'b01, 1'b0, 16'h0123, 16'h4567), 2'b11, 1'b0, "mulh_w_ignored");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic w;
      logic [XLEN-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      cfg_rdy_delay = $urandom_range(0, 3);
      cfg_lat = $urandom_range(0, 4);
      run_op(op, w, a, b, ref_res(op, w, a, b), ref_sgn(op), w && (op == 2'b00), "random");
    end
  endtask

  task automatic test_stall();
    int n, issue_cycles, x0;
    logic [XLEN-1:0] exp;
    cfg_rdy_delay = 2; cfg_lat = 2;
    wb_ready = 1'b0;
    exp = ref_res(2'b11, 1'b0, 16'h1234, 16'h00F1);
    x0 = wb_xfers;
    sb_q.push_back(exp);
    mul_op = 2'b11; is_w = 1'b0; src1 = 16'h1234; src2 = 16'h00F1; ex_valid = 1'b1;
    #1;
    n = 0;
    while (!ex_ready && n < 50) begin tick(); n++; end
    tick();
    ex_valid = 1'b0; src1 = 16'hDEAD; src2 = 16'hBEEF; mul_op = 2'b01;
    issue_cycles = 0;
    while (m_mul_valid && issue_cycles < 20) begin
      checks++;
      if (m_multiplicand !== 16'h1234 || m_mul_signed !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold: got a=%h sgn=%b, required a=1234 sgn=00", m_multiplicand, m_mul_signed);
      end
      issue_cycles++;
      tick();
    end
    checks++;
    if (issue_cycles != 3) begin
      errors++;
      $display("FAIL stall_issue_cycles: got %0d, required 3", issue_cycles);
    end
    n = 0;
    while (!wb_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp) begin
        errors++;
        $display("FAIL stall_wb_hold: got wbv=%b data=%h, required wbv=1 data=%h", wb_valid, wb_data, exp);
      end
      tick();
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (wb_xfers - x0 != 1) begin
      errors++;
      $display("FAIL stall_xfers: got %0d transfers, required 1", wb_xfers - x0);
    end
  endtask

  task automatic test_flush();
    int n, fl_cnt, wbv_cnt, x0;
    cfg_rdy_delay = 0; cfg_lat = 5;
    x0 = wb_xfers;
    mul_op = 2'b00; is_w = 1'b0; src1 = 16'h0101; src2 = 16'h0202; ex_valid = 1'b1;
    #1;
    n = 0;
    while (!ex_ready && n < 50) begin tick(); n++; end
    tick();
    ex_valid = 1'b0;
    n = 0;
    while (m_mul_valid && n < 50) begin tick(); n++; end
    flush = 1'b1;
    #1;
    fl_cnt = m_flush ? 1 : 0;
    wbv_cnt = 0;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ex_ready: got %b after flush, required 1", ex_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (m_flush) fl_cnt++;
      if (wb_valid) wbv_cnt++;
      tick();
    end
    checks++;
    if (fl_cnt != 1) begin
      errors++;
      $display("FAIL flush_pulse: got m_flush high %0d cycles, required 1", fl_cnt);
    end
    checks++;
    if (wbv_cnt != 0 || wb_xfers != x0) begin
      errors++;
      $display("FAIL flush_no_wb: got wb_valid cycles=%0d transfers=%0d, required 0 0", wbv_cnt, wb_xfers - x0);
    end
    cfg_lat = 1;
    run_op(2'b00, 1'b0, 16'h0003, 16'h0005, 16'h000F, 2'b11, 1'b0, "after_flush");
  endtask

  task automatic test_mid_reset();
    int n, fl_cnt;
    cfg_rdy_delay = 3; cfg_lat = 3;
    mul_op = 2'b01; is_w = 1'b0; src1 = 16'h0777; src2 = 16'h0999; ex_valid = 1'b1;
    #1;
    n = 0;
    while (!ex_ready && n < 50) begin tick(); n++; end
    tick();
    ex_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fl_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (m_flush) fl_cnt++;
      tick();
    end
    checks++;
    if (fl_cnt != 0 || ex_ready !== 1'b1 || m_mul_valid !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got m_flush cycles=%0d ex_ready=%b mv=%b wbv=%b, required 0 1 0 0",
               fl_cnt, ex_ready, m_mul_valid, wb_valid);
    end
  endtask

`ifdef MUL_RESULT_CACHE_EN
  task automatic test_cache();
    int n, mv0;
    cfg_rdy_delay = 1; cfg_lat = 2;
    run_op(2'b01, 1'b0, 16'h7FFF, 16'h7FFF, 16'h3FFF, 2'b11, 1'b0, "cache_fill");
    mv0 = mv_cycles;
    sb_q.push_back(16'h0001);
    mul_op = 2'b00; is_w = 1'b0; src1 = 16'h7FFF; src2 = 16'h7FFF; ex_valid = 1'b1;
    #1;
    n = 0;
    while (!ex_ready && n < 50) begin tick(); n++; end
    tick();
    ex_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL cache_latency: got wb_valid=%b one cycle after accept, required 1", wb_valid);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin tick(); n++; end
    checks++;
    if (mv_cycles != mv0 || n == 50) begin
      errors++;
      $display("FAIL cache_no_issue: got m_mul_valid cycles=%0d pending=%0d, required 0 0",
               mv_cycles - mv0, sb_q.size());
      sb_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_stall();
    test_flush();
    test_mid_reset();
`ifdef MUL_RESULT_CACHE_EN
    test_cache();
`endif
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Control stage between the execute unit and mul_booth_wallace_* multipliers.
- Accepts one RISC-V M-extension multiply op (MUL/MULH/MULHSU/MULHU/MULW).
- Translates the op into the multiplier's mul_valid/mul_signed/mulw handshake and holds operands stable until accepted.
- Captures result_hi/result_lo, then selects or sign-extends them into one XLEN writeback word behind a valid/ready handshake.
- Single outstanding operation; flush-aware.

Parameters:
XLEN, 64, operand/result width; W-ops use the low XLEN/2 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  op request from execute
ex_ready  out  1  request accepted when ex_valid&&ex_ready
mul_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
is_w  in  1  W variant; honoured only for MUL, ignored otherwise
src1  in  XLEN  rs1 value
src2  in  XLEN  rs2 value
flush  in  1  pipeline kill
m_mul_valid  out  1  to multiplier mul_valid
m_mul_ready  in  1  from multiplier mul_ready
m_mulw  out  1  to multiplier mulw
m_mul_signed  out  2  bit1 = multiplicand signed, bit0 = multiplier signed
m_multiplicand  out  XLEN  = latched src1
m_multiplier  out  XLEN  = latched src2
m_flush  out  1  to multiplier flush
m_out_valid  in  1  multiplier result valid
m_result_hi  in  XLEN  product upper half
m_result_lo  in  XLEN  product lower half
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts
wb_data  out  XLEN  formatted result

Behaviour:
- State machine: IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - state IDLE.
  - m_mul_valid 0, m_flush 0, wb_valid 0.
  - wb_data 0, operand registers 0, m_mul_signed 00, m_mulw 0.
- ex_ready = (state==IDLE) && !flush && !rst.
- IDLE: on accept, latch src1, src2, mul_op, is_w, then go to ISSUE.
  - Signedness: MUL/MULH -> 11, MULHSU -> 10, MULHU -> 00.
  - m_mulw = is_w && mul_op==MUL.
- ISSUE: m_mul_valid=1, outputs held constant. On m_mul_valid&&m_mul_ready -> WAIT, and m_mul_valid drops the next cycle.
- WAIT: m_out_valid is sampled only in this state. When sampled high, register the formatted result into wb_data -> RESP.
- Formatting:
  - MUL -> lo.
  - MULH/MULHSU/MULHU -> hi.
  - MULW -> sign-extend lo[XLEN/2-1:0].
- RESP: wb_valid = (state==RESP) && !flush. wb_data is stable while wb_valid && !wb_ready. On handshake -> IDLE.
- Latency: accept at cycle N; m_mul_valid at N+1; m_out_valid at cycle M -> wb_valid at M+1.
- Flush has priority over every handshake in the same cycle.
  - Next state IDLE; any pending result is discarded.
  - m_flush pulses for one cycle, only if state was ISSUE or WAIT.
  - Flush in RESP with wb_ready=1 is not a transfer.
- Reset mid-operation: return to IDLE immediately. The multiplier is reset by the same rst; no m_flush pulse.
- m_out_valid outside WAIT is ignored.

Optional Feature:
MUL_RESULT_CACHE_EN
- When defined, the block keeps an entry of {valid, src1, src2, signed-pair, hi, lo}.
  - Written on every non-W capture in WAIT.
  - Cleared by rst only; flush does not clear completed entries.
- Hit rules on accept:
  - MUL/MULW hit if src1 and src2 match, with any signed-pair.
  - High ops hit only if the signed-pair also matches.
- On a hit, go IDLE -> RESP with formatted data and wb_valid at N+1; m_mul_valid is never raised.
- When undefined, there is no cache storage and every op goes through ISSUE.

Decomposition:
- muldiv_pkg: mul_op encodings, signed-pair constants (SIGNED_UU/US/SU/SS), state enum.
- One combinational sub-module, mul_result_fmt: (op, is_w, hi, lo) -> XLEN word.

Test Plan:
The bench runs XLEN=16 with a behavioural multiplier model whose ready delay and result latency are variable.
1. src1=src2=0xFFFF: MUL -> 0x0001; MULH -> 0x0000; MULHU -> 0xFFFE. m_mul_signed is 11/11/00 respectively.
2. MULHSU src1=0xFFFE, src2=0x0005 -> m_mul_signed=10, wb_data 0xFFFF. MULHU on the same operands -> 0x0004.
3. MULW src1=0x0010, src2=0x0008 -> m_mulw=1, wb_data 0xFF80.
4. m_mul_ready delayed 2 cycles, then wb_ready low 3 cycles:
   - m_multiplicand and m_mul_signed stay stable during the ready delay.
   - wb_data stays stable during the wb_ready stall.
   - Exactly one wb transfer occurs.
5. Flush in WAIT:
   - m_flush is high for one cycle and no wb_valid follows.
   - ex_ready is high the next cycle.
   - A following MUL 0x0003*0x0005 -> 0x000F.
6. (MUL_RESULT_CACHE_EN) MULH 0x7FFF*0x7FFF -> 0x3FFF, then MUL on the same operands -> 0x0001 with wb_valid one cycle after accept and no m_mul_valid.
